// File: rtl/rf_pkg.sv
// Shared register-file constants and writeback requester IDs for the
// register-file write-port logic.
package rf_pkg;
  localparam int NREQ       = 3;
  localparam int DW         = 32;
  localparam int AW         = 5;
  localparam int REQ_ALU    = 0;
  localparam int REQ_LOAD   = 1;
  localparam int REQ_MULDIV = 2;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the first valid requester at or after ptr
// wins, and nothing is granted while hold is high.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic            hold,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      grant_idx
);
  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!hold && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx[1:0];
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// the writeback requesters; the winning write is registered onto the port.
module reg_write_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = rf_pkg::NREQ,
  parameter int DW   = rf_pkg::DW,
  parameter int AW   = rf_pkg::AW
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_reg,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               hold,
  output logic               RegWrite,
  output logic [AW-1:0]      WriteReg,
  output logic [DW-1:0]      WriteData,
  output logic [1:0]         grant_id,
  output logic               zero_drop,
  output logic [15:0]        wr_count
);
  logic [NREQ-1:0] grant;
  logic [1:0]      grant_idx;
  logic            arb_hold;
  logic            transfer;
  logic [AW-1:0]   sel_reg;
  logic [DW-1:0]   sel_data;

  logic [1:0]    ptr_q, ptr_d;
  logic          reg_write_q, reg_write_d;
  logic [AW-1:0] write_reg_q, write_reg_d;
  logic [DW-1:0] write_data_q, write_data_d;
  logic [1:0]    grant_id_q, grant_id_d;
  logic          zero_drop_q, zero_drop_d;
  logic [15:0]   wr_count_q, wr_count_d;

  // Reset also blocks the grant so req_ready stays low while reset_n is low.
  assign arb_hold = hold | ~reset_n;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req       (req_valid),
    .hold      (arb_hold),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign transfer  = |grant;
  assign sel_reg   = req_reg[int'(grant_idx)*AW +: AW];
  assign sel_data  = req_data[int'(grant_idx)*DW +: DW];

  always_comb begin
    ptr_d        = ptr_q;
    reg_write_d  = 1'b0;
    zero_drop_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    grant_id_d   = grant_id_q;
    wr_count_d   = wr_count_q;
    if (transfer) begin
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
      grant_id_d   = grant_idx;
      ptr_d        = (int'(grant_idx) == NREQ - 1) ? 2'd0 : grant_idx + 2'd1;
      // Register 0 is hardwired: the write is accepted but never performed.
      if (sel_reg != AW'(REG_ZERO)) begin
        reg_write_d = 1'b1;
        if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
      end else begin
        zero_drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      grant_id_q   <= '0;
      zero_drop_q  <= 1'b0;
      wr_count_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      grant_id_q   <= grant_id_d;
      zero_drop_q  <= zero_drop_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign RegWrite  = reg_write_q;
  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;
  assign grant_id  = grant_id_q;
  assign zero_drop = zero_drop_q;
  assign wr_count  = wr_count_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: grant vector table, output-port
// scoreboard and a register-file model fed from the write port.
module tb_reg_write_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic          reg_write;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [1:0]    grant_id;
    logic          zero_drop;
    logic [15:0]   wr_count;
  } out_t;

  typedef struct {
    logic [2:0] valid;
    logic       hold;
    logic [2:0] exp_ready;
    logic [1:0] exp_gid;
    logic       exp_we;
  } vec_t;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               hold;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_reg;
  logic [NREQ*DW-1:0] req_data;
  logic               reg_write;
  logic [AW-1:0]      write_reg;
  logic [DW-1:0]      write_data;
  logic [1:0]         grant_id;
  logic               zero_drop;
  logic [15:0]        wr_count;

  int   compared   = 0;
  int   mismatched = 0;
  int   m_ptr;
  out_t m_out;
  out_t exp_q[$];
  logic [2:0] g_fast;
  vec_t tbl[12];
  logic [DW-1:0] rf [32] = '{default: 32'h0};

  always #5 clock = ~clock;

  reg_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .hold      (hold),
    .RegWrite  (reg_write),
    .WriteReg  (write_reg),
    .WriteData (write_data),
    .grant_id  (grant_id),
    .zero_drop (zero_drop),
    .wr_count  (wr_count)
  );

  // The register file captures whatever the port presents, so a leaked $0 write shows up.
  always @(posedge clock) if (reg_write) rf[write_reg] <= write_data;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic out_t dut_out();
    return {reg_write, write_reg, write_data, grant_id, zero_drop, wr_count};
  endfunction

  function automatic logic [2:0] model_grant(input logic [2:0] v, input logic h, input int p);
    int i;
    if (h) return 3'b000;
    for (int k = 0; k < NREQ; k++) begin
      i = (p + k) % NREQ;
      if (v[i]) return 3'b001 << i;
    end
    return 3'b000;
  endfunction

  task automatic model_step(input logic [2:0] v, input logic h, output logic [2:0] g);
    int idx;
    g = model_grant(v, h, m_ptr);
    m_out.reg_write = 1'b0;
    m_out.zero_drop = 1'b0;
    if (g != 3'b000) begin
      idx = (g == 3'b001) ? 0 : (g == 3'b010) ? 1 : 2;
      m_out.write_reg  = req_reg[idx*AW +: AW];
      m_out.write_data = req_data[idx*DW +: DW];
      m_out.grant_id   = 2'(idx);
      if (m_out.write_reg != '0) begin
        m_out.reg_write = 1'b1;
        if (m_out.wr_count != 16'hFFFF) m_out.wr_count = m_out.wr_count + 16'd1;
      end else begin
        m_out.zero_drop = 1'b1;
      end
      m_ptr = (idx + 1) % NREQ;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check the grant, then check the port after the edge.
  task automatic applyStimulus(input logic [2:0] v, input logic h, input logic [2:0] exp_rdy,
                               input string name);
    logic [2:0] g;
    out_t e;
    @(negedge clock);
    req_valid = v;
    hold      = h;
    #1;
    checkOutput({name, ".ready"}, 64'(req_ready), 64'(exp_rdy));
    model_step(v, h, g);
    checkOutput({name, ".model_ready"}, 64'(req_ready), 64'(g));
    exp_q.push_back(m_out);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s.scoreboard: got empty queue, expected entry", name);
    end else begin
      e = exp_q.pop_front();
      checkOutput({name, ".port"}, 64'(dut_out()), 64'(e));
    end
  endtask

  task automatic do_reset(input logic [2:0] v);
    req_valid = v;
    hold      = 1'b0;
    reset_n   = 1'b0;
    #1;
    checkOutput("reset.port", 64'(dut_out()), 64'(0));
    checkOutput("reset.ready", 64'(req_ready), 64'(0));
    m_ptr = 0;
    m_out = '0;
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    req_reg[i*AW +: AW]  = r;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    req_reg  = '0;
    req_data = '0;
    do_reset(3'b000);

    // Reset in the middle of a registered write, then re-arbitrate from ptr 0.
    set_req(0, 5'd5, 32'hA5A5_0000);
    set_req(1, 5'd6, 32'hA5A5_0001);
    set_req(2, 5'd7, 32'hA5A5_0002);
    applyStimulus(3'b001, 1'b0, 3'b001, "rst_w");
    checkOutput("rst_w.regwrite", 64'(reg_write), 64'(1));
    do_reset(3'b110);
    applyStimulus(3'b110, 1'b0, 3'b010, "rst_first");
    checkOutput("rst_first.gid", 64'(grant_id), 64'(1));
    applyStimulus(3'b100, 1'b0, 3'b100, "rst_next");

    do_reset(3'b000);
    set_req(0, 5'd5, 32'h0000_0050);
    set_req(1, 5'd6, 32'h0000_0060);
    set_req(2, 5'd7, 32'h0000_0070);
    for (int n = 0; n < 6; n++) begin
      applyStimulus(3'b111, 1'b0, 3'b001 << (n % 3), "rr");
      checkOutput("rr.gid", 64'(grant_id), 64'(n % 3));
      checkOutput("rr.regwrite", 64'(reg_write), 64'(1));
    end
    checkOutput("rr.count", 64'(wr_count), 64'(6));
    applyStimulus(3'b011, 1'b0, 3'b001, "rr_drain0");
    applyStimulus(3'b010, 1'b0, 3'b010, "rr_drain1");

    do_reset(3'b000);
    tbl[0]  = '{3'b111, 1'b0, 3'b001, 2'd0, 1'b1};
    tbl[1]  = '{3'b110, 1'b0, 3'b010, 2'd1, 1'b1};
    tbl[2]  = '{3'b100, 1'b1, 3'b000, 2'd1, 1'b0};
    tbl[3]  = '{3'b101, 1'b0, 3'b100, 2'd2, 1'b1};
    tbl[4]  = '{3'b011, 1'b0, 3'b001, 2'd0, 1'b1};
    tbl[5]  = '{3'b010, 1'b0, 3'b010, 2'd1, 1'b1};
    tbl[6]  = '{3'b000, 1'b0, 3'b000, 2'd1, 1'b0};
    tbl[7]  = '{3'b011, 1'b0, 3'b001, 2'd0, 1'b1};
    tbl[8]  = '{3'b110, 1'b0, 3'b010, 2'd1, 1'b1};
    tbl[9]  = '{3'b111, 1'b0, 3'b100, 2'd2, 1'b1};
    tbl[10] = '{3'b011, 1'b0, 3'b001, 2'd0, 1'b1};
    tbl[11] = '{3'b010, 1'b0, 3'b010, 2'd1, 1'b1};
    for (int n = 0; n < 12; n++) begin
      applyStimulus(tbl[n].valid, tbl[n].hold, tbl[n].exp_ready, $sformatf("tbl%0d", n));
      checkOutput($sformatf("tbl%0d.gid", n), 64'(grant_id), 64'(tbl[n].exp_gid));
      checkOutput($sformatf("tbl%0d.we", n), 64'(reg_write), 64'(tbl[n].exp_we));
    end
    checkOutput("tbl.count", 64'(wr_count), 64'(10));

    // Register 0 write is accepted but suppressed.
    set_req(1, 5'd0, 32'hDEAD_BEEF);
    applyStimulus(3'b010, 1'b0, 3'b010, "zero");
    checkOutput("zero.regwrite", 64'(reg_write), 64'(0));
    checkOutput("zero.drop", 64'(zero_drop), 64'(1));
    checkOutput("zero.count", 64'(wr_count), 64'(10));
    applyStimulus(3'b000, 1'b0, 3'b000, "zero_idle");
    checkOutput("zero_idle.drop", 64'(zero_drop), 64'(0));
    checkOutput("zero.readback", 64'(rf[0]), 64'(0));

    set_req(0, 5'd9, 32'h1234_5678);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(3'b001, 1'b1, 3'b000, "hold");
      checkOutput("hold.regwrite", 64'(reg_write), 64'(0));
    end
    applyStimulus(3'b001, 1'b0, 3'b001, "hold_rel");
    checkOutput("hold_rel.port", 64'({reg_write, write_reg, write_data}),
                64'({1'b1, 5'd9, 32'h1234_5678}));
    applyStimulus(3'b000, 1'b0, 3'b000, "hold_idle");
    checkOutput("hold.readback", 64'(rf[9]), 64'(32'h1234_5678));

    // Move ptr to 2, then two writers collide on reg 4.
    set_req(1, 5'd3, 32'h0000_0033);
    applyStimulus(3'b010, 1'b0, 3'b010, "lww_setptr");
    set_req(0, 5'd4, 32'h0000_0001);
    set_req(2, 5'd4, 32'h0000_0002);
    applyStimulus(3'b101, 1'b0, 3'b100, "lww_first");
    checkOutput("lww_first.gid", 64'(grant_id), 64'(2));
    applyStimulus(3'b001, 1'b0, 3'b001, "lww_second");
    checkOutput("lww_second.gid", 64'(grant_id), 64'(0));
    applyStimulus(3'b000, 1'b0, 3'b000, "lww_idle");
    checkOutput("lww.readback", 64'(rf[4]), 64'(32'h1));
    checkOutput("lww.count", 64'(wr_count), 64'(14));

    do_reset(3'b000);
    set_req(0, 5'd5, 32'h0000_0500);
    set_req(1, 5'd6, 32'h0000_0600);
    set_req(2, 5'd7, 32'h0000_0700);
    @(negedge clock);
    req_valid = 3'b111;
    hold      = 1'b0;
    for (int n = 0; n < 65534; n++) begin
      @(posedge clock);
      model_step(3'b111, 1'b0, g_fast);
    end
    #1;
    checkOutput("sat.preload", 64'(wr_count), 64'(16'hFFFE));
    checkOutput("sat.port", 64'(dut_out()), 64'(m_out));
    applyStimulus(3'b111, 1'b0, 3'b100, "sat1");
    applyStimulus(3'b111, 1'b0, 3'b001, "sat2");
    applyStimulus(3'b111, 1'b0, 3'b010, "sat3");
    checkOutput("sat.count", 64'(wr_count), 64'(16'hFFFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
